line_buffer_ctrl: RTL and testbench



---
 rtl/line_buffer_ctrl_pkg.sv | 31 +++
 rtl/wrap_counter.sv | 38 +++
 rtl/line_buffer_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_line_buffer_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/line_buffer_ctrl_pkg.sv
// rtl/line_buffer_ctrl_pkg.sv - shared geometry, select-width helper and FSM encoding for the line buffer controller
//
// Purpose: constants and types shared by line_buffer_ctrl and its helpers.
//   DEF_IMG_W / DEF_IMG_H / DEF_NUM_BANKS : default frame geometry
//   sel_width(n)                          : bank select width for n banks (never below 1)
//   lb_state_e                            : 3-bit controller state encoding
//   cnt_width(n)                          : counter width able to hold 0..n-1 (never below 1)

package line_buffer_ctrl_pkg;

  localparam int DEF_IMG_W     = 512;
  localparam int DEF_IMG_H     = 512;
  localparam int DEF_NUM_BANKS = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREFILL = 3'd1,
    ST_STREAM  = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } lb_state_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - modulo-MOD up counter with enable, clear and terminal-count flag
//
// Purpose: counts 0..MOD-1 on each enabled cycle and wraps to 0.
// Ports:
//   CLK    in   clock, posedge
//   rst    in   synchronous active-high reset, clears count
//   clr    in   synchronous clear, same effect as rst, lower priority
//   en     in   advance by one this cycle
//   count  out  current value
//   tc     out  count is at its terminal value MOD-1 (independent of en)

module wrap_counter
  import line_buffer_ctrl_pkg::*;
#(
  parameter int MOD = 4,
  parameter int W   = cnt_width(MOD)
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign tc = (count == LAST);

  always_ff @(posedge CLK) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/line_buffer_ctrl.sv
// rtl/line_buffer_ctrl.sv - control FSM for a multi-bank BRAM line buffer feeding a K-row window
//
// Purpose: prefills K = NUM_BANKS-1 rows, then streams each accepted pixel into
// the next bank while reading the K-row column window from the others, then
// drains the final window row and pulses complete.
// Ports:
//   CLK            in   clock, posedge
//   rst            in   synchronous active-high reset
//   start          in   begin a frame (only honoured in IDLE)
//   abort          in   return to IDLE at the next edge, no completion
//   pix_valid      in   external memory presents a pixel
//   out_ready      in   window consumer accepts this cycle
//   e_mem_addr_en  out  advance external read address (same as wr_en)
//   wr_en          out  BRAM port A write enable
//   wr_bank        out  bank receiving the current row
//   wr_addr        out  write column
//   rd_en          out  BRAM port B read enable for all window banks
//   rd_bank_base   out  bank holding the oldest window row
//   rd_addr        out  read column
//   win_valid      out  window data valid on BRAM outputs (rd_en delayed one cycle)
//   stall          out  pixel available but downstream not ready
//   busy           out  not IDLE
//   complete       out  one-cycle frame-end pulse
//   row_cnt        out  current write row

module line_buffer_ctrl
  import line_buffer_ctrl_pkg::*;
#(
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int AW        = $clog2(IMG_W),
  parameter int SW        = sel_width(NUM_BANKS),
  parameter int RW        = $clog2(IMG_H)
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          pix_valid,
  input  logic          out_ready,
  output logic          e_mem_addr_en,
  output logic          wr_en,
  output logic [SW-1:0] wr_bank,
  output logic [AW-1:0] wr_addr,
  output logic          rd_en,
  output logic [SW-1:0] rd_bank_base,
  output logic [AW-1:0] rd_addr,
  output logic          win_valid,
  output logic          stall,
  output logic          busy,
  output logic          complete,
  output logic [RW-1:0] row_cnt
);

  localparam int K = NUM_BANKS - 1;
  localparam logic [RW-1:0] LAST_PREFILL_ROW = RW'(K - 1);

  lb_state_e state, state_nxt;

  logic [AW-1:0] wr_col, rd_col;
  logic [RW-1:0] wr_row;
  logic [SW-1:0] wr_bank_q, rd_bank_q;
  logic          wr_col_tc, rd_col_tc, wr_row_tc;
  logic          unused_wr_bank_tc, unused_rd_bank_tc;
  logic          cnt_clr;

  // Counters return to zero on abort and when leaving DONE so every frame
  // starts from bank 0 regardless of how many rows the previous frame had.
  assign cnt_clr = abort || (state == ST_DONE);

  // ---------------- state register ----------------
  always_ff @(posedge CLK) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state_nxt = ST_PREFILL;
        end
        ST_PREFILL: begin
          // last column of the last prefill row
          if (wr_en && wr_col_tc && (wr_row == LAST_PREFILL_ROW)) state_nxt = ST_STREAM;
        end
        ST_STREAM: begin
          if (wr_en && wr_col_tc && wr_row_tc) state_nxt = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (rd_en && rd_col_tc) state_nxt = ST_DONE;
        end
        ST_DONE: begin
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------- output decode ----------------
  always_comb begin
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    stall    = 1'b0;
    complete = 1'b0;
    busy     = (state != ST_IDLE);
    case (state)
      ST_PREFILL: begin
        wr_en = pix_valid;
      end
      ST_STREAM: begin
        // write and read move in lockstep so the window column tracks the write column
        wr_en = pix_valid && out_ready;
        rd_en = pix_valid && out_ready;
        stall = pix_valid && !out_ready;
      end
      ST_DRAIN: begin
        rd_en = out_ready;
      end
      ST_DONE: begin
        complete = !abort;
      end
      default: begin
      end
    endcase
  end

  assign e_mem_addr_en = wr_en;

  // rd_en is dropped on abort so win_valid is never seen high in IDLE.
  always_ff @(posedge CLK) begin
    if (rst) begin
      win_valid <= 1'b0;
    end else begin
      win_valid <= rd_en && !abort;
    end
  end

  // ---------------- address / pointer counters ----------------
  wrap_counter #(.MOD(IMG_W), .W(AW)) u_wr_col (
    .CLK   (CLK),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (wr_en),
    .count (wr_col),
    .tc    (wr_col_tc)
  );

  wrap_counter #(.MOD(IMG_H), .W(RW)) u_wr_row (
    .CLK   (CLK),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (wr_en && wr_col_tc),
    .count (wr_row),
    .tc    (wr_row_tc)
  );

  wrap_counter #(.MOD(NUM_BANKS), .W(SW)) u_wr_bank (
    .CLK   (CLK),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (wr_en && wr_col_tc),
    .count (wr_bank_q),
    .tc    (unused_wr_bank_tc)
  );

  wrap_counter #(.MOD(IMG_W), .W(AW)) u_rd_col (
    .CLK   (CLK),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (rd_en),
    .count (rd_col),
    .tc    (rd_col_tc)
  );

  // The read base trails the write bank by K rows, so it never points at the
  // bank being written while streaming.
  wrap_counter #(.MOD(NUM_BANKS), .W(SW)) u_rd_bank (
    .CLK   (CLK),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (rd_en && rd_col_tc),
    .count (rd_bank_q),
    .tc    (unused_rd_bank_tc)
  );

  assign wr_addr      = wr_col;
  assign rd_addr      = rd_col;
  assign wr_bank      = wr_bank_q;
  assign rd_bank_base = rd_bank_q;
  assign row_cnt      = wr_row;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb/tb_line_buffer_ctrl.sv - directed self-checking bench for line_buffer_ctrl (8x6 frame, 4 banks)

module tb_line_buffer_ctrl;

  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int NB    = 4;
  localparam int AW    = 3;
  localparam int SW    = 2;
  localparam int RW    = 3;
  localparam int OFF   = 1000;

  logic          CLK = 1'b0;
  logic          rst, start, abort, pix_valid, out_ready;
  logic          e_mem_addr_en, wr_en, rd_en, win_valid, stall, busy, complete;
  logic [SW-1:0] wr_bank, rd_bank_base;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [RW-1:0] row_cnt;

  always #5 CLK = ~CLK;

  line_buffer_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .NUM_BANKS(NB)) dut (
    .CLK           (CLK),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .pix_valid     (pix_valid),
    .out_ready     (out_ready),
    .e_mem_addr_en (e_mem_addr_en),
    .wr_en         (wr_en),
    .wr_bank       (wr_bank),
    .wr_addr       (wr_addr),
    .rd_en         (rd_en),
    .rd_bank_base  (rd_bank_base),
    .rd_addr       (rd_addr),
    .win_valid     (win_valid),
    .stall         (stall),
    .busy          (busy),
    .complete      (complete),
    .row_cnt       (row_cnt)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // per-run observations
  int n_wr, n_rd, n_wv, n_wr_only, n_rd_only, n_cmp, cmp_cyc, n_stall;
  int n_wv_bad, n_coll, bp_act, addr_moves, stall_emem, end_busy;
  int wa3, wa7, snap_busy, snap_cnt, stop_cyc;
  int wrb[$];
  int rdb[$];

  function automatic logic [13:0] cnt_vec();
    return {wr_addr, rd_addr, row_cnt, wr_bank, rd_bank_base, win_valid};
  endfunction

  task automatic run_frame(input int bp_at, input int bp_len, input bit gap,
                           input int abort_at, input int rst_at, input int start_at);
    logic          prev_rd;
    logic [AW-1:0] prev_wa, prev_ra;
    n_wr = 0; n_rd = 0; n_wv = 0; n_wr_only = 0; n_rd_only = 0; n_cmp = 0;
    cmp_cyc = 0; n_stall = 0; n_wv_bad = 0; n_coll = 0; bp_act = 0; addr_moves = 0;
    stall_emem = 0; end_busy = -1; wa3 = -1; wa7 = -1; snap_busy = -1; snap_cnt = -1;
    stop_cyc = 0;
    wrb.delete(); rdb.delete();
    prev_rd = 1'b0; prev_wa = '0; prev_ra = '0;
    @(posedge CLK); #1;
    start = 1'b1; pix_valid = 1'b1; out_ready = 1'b1; abort = 1'b0;
    for (int n = 1; n <= 150; n++) begin
      @(posedge CLK); #1;
      start     = (n == start_at);
      pix_valid = !(gap && (n == 4 || n == 6));
      out_ready = !(n >= bp_at && n < bp_at + bp_len);
      abort     = (n == abort_at);
      rst       = (n == rst_at);
      @(negedge CLK);
      stop_cyc = n;
      n_wr += int'(wr_en);
      n_rd += int'(rd_en);
      n_wv += int'(win_valid);
      if (wr_en && !rd_en) n_wr_only++;
      if (rd_en && !wr_en) n_rd_only++;
      if (win_valid != prev_rd) n_wv_bad++;
      prev_rd = rd_en;
      if (wr_en && wr_addr == 0) wrb.push_back(int'(wr_bank));
      if (rd_en && rd_addr == 0) rdb.push_back(int'(rd_bank_base));
      if (rd_en) begin
        for (int k = 0; k < NB - 1; k++)
          if (int'(wr_bank) == (int'(rd_bank_base) + k) % NB) n_coll++;
      end
      n_stall += int'(stall);
      if (stall && e_mem_addr_en) stall_emem++;
      if (n >= bp_at && n < bp_at + bp_len && (wr_en || rd_en || e_mem_addr_en)) bp_act++;
      if (n > bp_at && n <= bp_at + bp_len && (wr_addr != prev_wa || rd_addr != prev_ra))
        addr_moves++;
      prev_wa = wr_addr;
      prev_ra = rd_addr;
      if (n == 3) wa3 = int'(wr_addr);
      if (n == 7) wa7 = int'(wr_addr);
      if (complete) begin
        n_cmp++;
        cmp_cyc = n;
      end
      if (n == abort_at + 1 || n == rst_at + 1) begin
        snap_busy = int'(busy);
        snap_cnt  = int'(cnt_vec());
        break;
      end
      if (cmp_cyc > 0 && n == cmp_cyc + 2) begin
        end_busy = int'(busy);
        break;
      end
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
  endtask

  task automatic check_full_frame(input string tag, input int exp_cmp);
    chk({tag, "_complete_cycle"}, cmp_cyc, exp_cmp);
    chk({tag, "_complete_count"}, n_cmp, 1);
    chk({tag, "_writes"}, n_wr, IMG_W * IMG_H);
    chk({tag, "_reads"}, n_rd, (IMG_H - (NB - 1) + 1) * IMG_W);
    chk({tag, "_idle_after"}, end_busy, 0);
  endtask

  initial begin
    int exp_wrb[6] = '{0, 1, 2, 3, 0, 1};
    int exp_rdb[4] = '{0, 1, 2, 3};
    rst = 1'b1; start = 1'b0; abort = 1'b0; pix_valid = 1'b0; out_ready = 1'b0;

    // reset state
    repeat (3) @(posedge CLK);
    #1 pix_valid = 1'b1; out_ready = 1'b1;
    @(negedge CLK);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_stall", int'(stall), 0);
    chk("rst_complete", int'(complete), 0);
    chk("rst_counters", int'(cnt_vec()), 0);
    @(posedge CLK); #1 rst = 1'b0;

    // continuous run
    run_frame(OFF, 0, 1'b0, OFF, OFF, OFF);
    check_full_frame("cont", 57);
    chk("cont_win_valid", n_wv, 32);
    chk("cont_win_valid_lag", n_wv_bad, 0);
    chk("cont_prefill_writes", n_wr_only, 24);
    chk("cont_drain_reads", n_rd_only, 8);
    chk("cont_stall", n_stall, 0);
    chk("cont_bank_collision", n_coll, 0);
    chk("cont_wrb_rows", wrb.size(), 6);
    for (int i = 0; i < 6 && i < wrb.size(); i++) chk($sformatf("cont_wr_bank_row%0d", i), wrb[i], exp_wrb[i]);
    chk("cont_rdb_rows", rdb.size(), 4);
    for (int i = 0; i < 4 && i < rdb.size(); i++) chk($sformatf("cont_rd_base_row%0d", i), rdb[i], exp_rdb[i]);

    // backpressure: out_ready low for cycles 30..34 of STREAM
    run_frame(30, 5, 1'b0, OFF, OFF, OFF);
    check_full_frame("bp", 62);
    chk("bp_stall_cycles", n_stall, 5);
    chk("bp_enables_low", bp_act, 0);
    chk("bp_addr_hold", addr_moves, 0);
    chk("bp_emem_during_stall", stall_emem, 0);

    // prefill input gaps: pix_valid 1,0,1,0 over cycles 3..6
    run_frame(OFF, 0, 1'b1, OFF, OFF, OFF);
    check_full_frame("gap", 59);
    chk("gap_col_advance", wa7 - wa3, 2);
    chk("gap_stall", n_stall, 0);

    // abort at STREAM fire #10 (cycle 34), then a normal frame
    run_frame(OFF, 0, 1'b0, 34, OFF, OFF);
    chk("abort_busy", snap_busy, 0);
    chk("abort_counters", snap_cnt, 0);
    chk("abort_no_complete", n_cmp, 0);
    chk("abort_stop_cycle", stop_cyc, 35);
    run_frame(OFF, 0, 1'b0, OFF, OFF, OFF);
    check_full_frame("after_abort", 57);

    // reset at the same point, then a normal frame
    run_frame(OFF, 0, 1'b0, OFF, 34, OFF);
    chk("midrst_busy", snap_busy, 0);
    chk("midrst_counters", snap_cnt, 0);
    chk("midrst_no_complete", n_cmp, 0);
    run_frame(OFF, 0, 1'b0, OFF, OFF, OFF);
    check_full_frame("after_rst", 57);

    // start during DRAIN is ignored
    run_frame(OFF, 0, 1'b0, OFF, OFF, 50);
    check_full_frame("drain_start", 57);

    // start together with abort in IDLE
    @(posedge CLK); #1 start = 1'b1; abort = 1'b1;
    @(posedge CLK); #1 start = 1'b0; abort = 1'b0;
    @(negedge CLK);
    chk("start_abort_busy", int'(busy), 0);
    @(negedge CLK);
    chk("start_abort_busy2", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
